iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider; slave end of the divider stream interface driven by EXE.
//  Accepts divisor/dividend via valid/ready, returns {quotient, remainder} on a master stream.
//  One instance per signedness (SIGNED=1 for div.w/mod.w, SIGNED=0 for div.wu/mod.wu).
// PARAMETERS
//  WIDTH   32  operand width in bits; result bus is 2*WIDTH
//  SIGNED  1   1: two's-complement operands/results; 0: unsigned
// PORTS
//  clk                     in   1        clock
//  reset                   in   1        synchronous, active-high
//  s_axis_divisor_tdata    in   WIDTH    divisor (rk)
//  s_axis_divisor_tvalid   in   1        divisor valid
//  s_axis_divisor_tready   out  1        divisor ready
//  s_axis_dividend_tdata   in   WIDTH    dividend (rj)
//  s_axis_dividend_tvalid  in   1        dividend valid
//  s_axis_dividend_tready  out  1        dividend ready
//  m_axis_dout_tdata       out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}
//  m_axis_dout_tvalid      out  1        result valid
//  m_axis_dout_tready      in   1        result consumed; tie 1 for single-cycle pulse
// BEHAVIOUR
//  - Reset, sync active-high; after it: state IDLE, both s_*_tready=1, m_axis_dout_tvalid=0, tdata=0.
//  - Reset mid-operation abandons the division; no result is produced.
//  - States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - Both s_*_tready = (state==IDLE); they are always equal.
//  - Accept only when both tvalid=1 in IDLE; with only one valid, nothing is latched.
//  - Handshake cycle T: operands latched, counter=WIDTH-1, state CALC.
//  - CALC: one quotient bit per cycle, MSB first, on |dividend| and |divisor|
//    (magnitudes only when SIGNED); partial remainder WIDTH+1 bits; WIDTH cycles.
//  - FIX (1 cycle): quotient negated if signs differ; remainder takes the dividend's sign (truncation toward zero).
//  - DONE: tvalid=1 from cycle T+WIDTH+2; tdata stable while tvalid=1 and tready=0.
//  - DONE exits when tready=1 (same edge -> IDLE); tvalid drops the following cycle.
//  - No new operands are accepted in the DONE cycle; earliest next accept is one cycle after the result is consumed.
//  - Divide by zero: quotient = all ones, remainder = dividend (both signednesses).
//  - Signed overflow, INT_MIN / -1: quotient = INT_MIN, remainder = 0 (W-bit wraparound of the magnitude result).
//  - Magnitude of INT_MIN handled as an unsigned W-bit value; no extra width is needed beyond WIDTH+1.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined: divisor==0 at accept goes IDLE->DONE directly; tvalid at T+1; result as above.
//  DIV_ZERO_FAST_EN undefined: divisor==0 runs full CALC/FIX; latency T+WIDTH+2.
//  The result for divide by zero is identical either way.
// STRUCTURE
//  Package div_pkg: state enum (IDLE, CALC, FIX, DONE), default WIDTH constant, counter width $clog2(WIDTH).
//  Sub-module div_step: combinational single restoring step.
//    Inputs: partial remainder, divisor magnitude, next dividend bit.
//    Outputs: new partial remainder, quotient bit.
//  Top holds the FSM, counter, operand/result registers and sign fix.
// TESTING
//  1. SIGNED=0, 7/2, dout_tready=1 -> tvalid one cycle at T+34, tdata={32'd3,32'd1}.
//  2. SIGNED=1, -7/2 -> q=32'hFFFFFFFD, r=32'hFFFFFFFF; and 7/-2 -> q=32'hFFFFFFFD, r=32'd1.
//  3. SIGNED=1, 32'h80000000 / 32'hFFFFFFFF -> q=32'h80000000, r=0;
//     SIGNED=0, 32'hFFFFFFFF/1 -> q=32'hFFFFFFFF, r=0.
//  4. 5/0, each SIGNED -> q=32'hFFFFFFFF, r=5.
//     Latency T+1 with DIV_ZERO_FAST_EN, T+34 without.
//  5. Hold dout_tready=0 for 3 cycles in DONE -> tvalid and tdata held.
//     s_*_tready stay 0; on tready=1, IDLE next cycle.
//  6. Dividend valid only (divisor invalid) 4 cycles -> no accept.
//     Reset asserted mid-CALC -> tvalid stays 0; s_*_tready=1 the cycle after reset.
//     A new 100/7 -> q=14, r=2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

   // Divider control states: operand wait, bit iteration, sign fix, result hold
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dvsr_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] rem_o,
   output logic             q_o
);

   // The shifted partial remainder needs WIDTH+1 bits; after the trial
   // subtraction it is always below the divisor, so it fits back in WIDTH.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] dvsr_ext;

   // Restoring step: keep the difference only when it does not go negative
   always_comb begin
      shifted  = {rem_i, bit_i};
      dvsr_ext = {1'b0, dvsr_i};
      q_o      = (shifted >= dvsr_ext);
      rem_o    = q_o ? WIDTH'(shifted - dvsr_ext) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider, result {quotient, remainder}; optional macro DIV_ZERO_FAST_EN.
// Latency: result valid WIDTH+2 cycles after accept (1 cycle for divide-by-zero with DIV_ZERO_FAST_EN).
// Backpressure: result held in DONE until m_axis_dout_tready; operand ready only while IDLE.
module iter_divider
   import div_pkg::*;
#(
   parameter int WIDTH  = DIV_WIDTH,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata,
   output logic               m_axis_dout_tvalid,
   input  logic               m_axis_dout_tready
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   rem_q;      // partial remainder
   logic [WIDTH-1:0]   quo_q;      // dividend bits shift out of the top, quotient bits in at the bottom
   logic [WIDTH-1:0]   dvsr_q;     // divisor magnitude
   logic [WIDTH-1:0]   dvnd_q;     // raw dividend, returned as remainder on divide-by-zero
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic               dz_q;
   logic [2*WIDTH-1:0] dout_q;
   logic               dout_vld_q;
   logic               in_rdy_q;

   logic               accept;
   logic [WIDTH-1:0]   dvnd_mag;
   logic [WIDTH-1:0]   dvsr_mag;
   logic [WIDTH-1:0]   rem_d;
   logic               qbit_d;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign s_axis_divisor_tready  = in_rdy_q;
   assign s_axis_dividend_tready = in_rdy_q;
   assign m_axis_dout_tdata      = dout_q;
   assign m_axis_dout_tvalid     = dout_vld_q;

   // Operand magnitudes and accept condition; INT_MIN negates to itself, which is its correct unsigned magnitude
   always_comb begin
      accept   = (state_q == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;
      dvnd_mag = (SIGNED && s_axis_dividend_tdata[WIDTH-1]) ? -s_axis_dividend_tdata
                                                            : s_axis_dividend_tdata;
      dvsr_mag = (SIGNED && s_axis_divisor_tdata[WIDTH-1])  ? -s_axis_divisor_tdata
                                                            : s_axis_divisor_tdata;
   end

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (rem_q),
      .dvsr_i (dvsr_q),
      .bit_i  (quo_q[WIDTH-1]),
      .rem_o  (rem_d),
      .q_o    (qbit_d)
   );

   // Sign correction: truncation toward zero, remainder follows the dividend's sign
   always_comb begin
      quo_fix = neg_quo_q ? -quo_q : quo_q;
      rem_fix = neg_rem_q ? -rem_q : rem_q;
   end

   // Control FSM with datapath registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvsr_q     <= '0;
         dvnd_q     <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         in_rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  dvnd_q    <= s_axis_dividend_tdata;
                  dvsr_q    <= dvsr_mag;
                  quo_q     <= dvnd_mag;
                  rem_q     <= '0;
                  cnt_q     <= CW'(WIDTH - 1);
                  neg_quo_q <= SIGNED && (s_axis_dividend_tdata[WIDTH-1] ^ s_axis_divisor_tdata[WIDTH-1]);
                  neg_rem_q <= SIGNED && s_axis_dividend_tdata[WIDTH-1];
                  dz_q      <= (s_axis_divisor_tdata == '0);
                  in_rdy_q  <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                  if (s_axis_divisor_tdata == '0) begin
                     dout_q     <= {{WIDTH{1'b1}}, s_axis_dividend_tdata};
                     dout_vld_q <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     state_q    <= CALC;
                  end
`else
                  state_q   <= CALC;
`endif
               end
            end
            CALC: begin
               rem_q <= rem_d;
               quo_q <= {quo_q[WIDTH-2:0], qbit_d};
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == '0) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               // Divide-by-zero overrides the sign fix so the quotient is all ones for any sign
               dout_q     <= dz_q ? {{WIDTH{1'b1}}, dvnd_q} : {quo_fix, rem_fix};
               dout_vld_q <= 1'b1;
               state_q    <= DONE;
            end
            DONE: begin
               if (m_axis_dout_tready) begin
                  dout_vld_q <= 1'b0;
                  in_rdy_q   <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q  <= IDLE;
               in_rdy_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: one unsigned (index 0) and one signed (index 1) instance.
// Expected results are queued when operands are driven and compared when the result appears.
// Also covers latency, result hold under backpressure, partial-valid rejection and mid-op reset.
module tb_iter_divider;

   localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam int LAT_DZ = 1;
`else
   localparam int LAT_DZ = W + 2;
`endif
   localparam int LAT = W + 2;

   logic          clk;
   logic          reset;
   logic [W-1:0]  dv_dat  [2];
   logic          dv_vld  [2];
   logic          dv_rdy  [2];
   logic [W-1:0]  dd_dat  [2];
   logic          dd_vld  [2];
   logic          dd_rdy  [2];
   logic [2*W-1:0] out_dat [2];
   logic          out_vld [2];
   logic          out_rdy [2];

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] sb[$];

   iter_divider #(.WIDTH(W), .SIGNED(1'b0)) u_udiv (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_divisor_tdata   (dv_dat[0]),
      .s_axis_divisor_tvalid  (dv_vld[0]),
      .s_axis_divisor_tready  (dv_rdy[0]),
      .s_axis_dividend_tdata  (dd_dat[0]),
      .s_axis_dividend_tvalid (dd_vld[0]),
      .s_axis_dividend_tready (dd_rdy[0]),
      .m_axis_dout_tdata      (out_dat[0]),
      .m_axis_dout_tvalid     (out_vld[0]),
      .m_axis_dout_tready     (out_rdy[0])
   );

   iter_divider #(.WIDTH(W), .SIGNED(1'b1)) u_sdiv (
      .clk                    (clk),
      .reset                  (reset),
      .s_axis_divisor_tdata   (dv_dat[1]),
      .s_axis_divisor_tvalid  (dv_vld[1]),
      .s_axis_divisor_tready  (dv_rdy[1]),
      .s_axis_dividend_tdata  (dd_dat[1]),
      .s_axis_dividend_tvalid (dd_vld[1]),
      .s_axis_dividend_tready (dd_rdy[1]),
      .m_axis_dout_tdata      (out_dat[1]),
      .m_axis_dout_tvalid     (out_vld[1]),
      .m_axis_dout_tready     (out_rdy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division, with divide-by-zero and overflow cases spelled out
   function automatic logic [63:0] model(input int sel, input logic [W-1:0] dd, input logic [W-1:0] dv);
      logic signed [W-1:0] a, b, q, r;
      if (dv == '0) return {32'hFFFF_FFFF, dd};
      if (sel == 0) return {dd / dv, dd % dv};
      if (dd == 32'h8000_0000 && dv == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      a = dd;
      b = dv;
      q = a / b;
      r = a % b;
      return {q, r};
   endfunction

   // Drive one division, push its expected result, then check latency, data, hold and release
   task automatic run_div(input string tag, input int sel, input logic [W-1:0] dd,
                          input logic [W-1:0] dv, input logic [63:0] exp, input int hold);
      int cyc;
      int lat;
      logic [63:0] got;
      lat = (dv == '0) ? LAT_DZ : LAT;
      @(negedge clk);
      chk({tag, " in_rdy"}, {62'd0, dv_rdy[sel], dd_rdy[sel]}, 64'd3);
      out_rdy[sel] = (hold == 0);
      dd_dat[sel]  = dd;
      dv_dat[sel]  = dv;
      dd_vld[sel]  = 1'b1;
      dv_vld[sel]  = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      dd_vld[sel] = 1'b0;
      dv_vld[sel] = 1'b0;
      cyc = 1;
      while (!out_vld[sel] && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(lat));
      got = out_dat[sel];
      chk({tag, " result"}, got, sb.pop_front());
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk({tag, " held vld/in_rdy"}, {62'd0, out_vld[sel], dv_rdy[sel]}, 64'd2);
         chk({tag, " held data"}, out_dat[sel], got);
      end
      if (hold != 0) begin
         @(negedge clk);
         out_rdy[sel] = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({tag, " release vld/in_rdy"}, {62'd0, out_vld[sel], dv_rdy[sel]}, 64'd1);
   endtask

   initial begin
      logic [W-1:0] rdd, rdv;
      bit seen;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         dv_dat[i]  = '0;
         dd_dat[i]  = '0;
         dv_vld[i]  = 1'b0;
         dd_vld[i]  = 1'b0;
         out_rdy[i] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("reset rdy/vld", {62'd0, dv_rdy[i] & dd_rdy[i], out_vld[i]}, 64'd2);
         chk("reset tdata", out_dat[i], 64'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      run_div("u 7/2",      0, 32'd7,          32'd2,          {32'd3, 32'd1}, 0);
      run_div("s -7/2",     1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 0);
      run_div("s 7/-2",     1, 32'd7,          32'hFFFF_FFFE,  {32'hFFFF_FFFD, 32'd1}, 0);
      run_div("s min/-1",   1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0}, 0);
      run_div("u max/1",    0, 32'hFFFF_FFFF,  32'd1,          {32'hFFFF_FFFF, 32'd0}, 0);
      run_div("s 5/0",      1, 32'd5,          32'd0,          {32'hFFFF_FFFF, 32'd5}, 0);
      run_div("u 5/0",      0, 32'd5,          32'd0,          {32'hFFFF_FFFF, 32'd5}, 0);
      run_div("s -5/0",     1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 0);
      run_div("u hold",     0, 32'd100,        32'd7,          {32'd14, 32'd2}, 3);

      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < 2; s++) begin
            rdd = $urandom;
            rdv = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
            if (rdv == '0) rdv = 32'd3;
            run_div("rand", s, rdd, rdv, model(s, rdd, rdv), 0);
         end
      end

      // Dividend alone must not be accepted
      @(negedge clk);
      dd_dat[1] = 32'd9;
      dd_vld[1] = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("partial valid rdy/vld", {62'd0, dv_rdy[1], out_vld[1]}, 64'd2);
      end
      @(negedge clk);
      dd_vld[1] = 1'b0;

      // Reset in the middle of CALC abandons the division
      dd_dat[1] = 32'd50;
      dv_dat[1] = 32'd3;
      dd_vld[1] = 1'b1;
      dv_vld[1] = 1'b1;
      @(posedge clk);
      #1;
      dd_vld[1] = 1'b0;
      dv_vld[1] = 1'b0;
      chk("busy in_rdy", {63'd0, dv_rdy[1]}, 64'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("post-reset rdy/vld", {62'd0, dv_rdy[1] & dd_rdy[1], out_vld[1]}, 64'd2);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_vld[1]) seen = 1'b1;
      end
      chk("no result after reset", {63'd0, seen}, 64'd0);

      run_div("s 100/7", 1, 32'd100, 32'd7, {32'd14, 32'd2}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
